// File: rtl/mem_if_pkg.sv
// Shared types for the data-memory request/status interface.
// status_t doubles as the responder FSM state encoding.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } status_t;

    // Any set bit here in a byte address means the request is not word aligned.
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM with a registered read-data output.
// The storage is not reset; only the read-data register is.
module dmem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       w_data,
    output logic [31:0]       r_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= w_data;
        end
    end

    // r_data only moves on a read, so it holds the last completed read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (re) begin
            r_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts single-word requests, waits LATENCY cycles in BUSY,
// then commits the write or returns read data on the edge that enters DONE.
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        write_enabled,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic [1:0]  status
);

    localparam int unsigned CNT_W = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    status_t           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_idx_q;
    logic [31:0]       req_wdata_q;

    logic              addr_err;
    logic              accept;
    logic              complete;
    logic              op_we;
    logic [ADDR_W-1:0] addr_idx;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       op_wdata;

    assign addr_idx = addr[ADDR_W+1:2];
    assign addr_err = ((addr & ALIGN_MASK) != '0) || ((addr >> (ADDR_W + 2)) != '0);
    assign accept   = valid && (state_q != BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == BUSY) begin
            if (cnt_q == '0) begin
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (valid) begin
            if (addr_err) begin
                state_d = ERROR;
            end else if (LATENCY == 0) begin
                state_d = DONE;
            end else begin
                state_d = BUSY;
                cnt_d   = CNT_LOAD;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // With LATENCY = 0 the accepting edge is also the completion edge, so the
    // memory must see the live request rather than the captured one.
    assign complete = (state_d == DONE);
    assign op_we    = (state_q == BUSY) ? req_we_q    : write_enabled;
    assign op_idx   = (state_q == BUSY) ? req_idx_q   : addr_idx;
    assign op_wdata = (state_q == BUSY) ? req_wdata_q : w_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_we_q    <= write_enabled;
                req_idx_q   <= addr_idx;
                req_wdata_q <= w_data;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (complete && op_we),
        .re     (complete && !op_we),
        .idx    (op_idx),
        .w_data (op_wdata),
        .r_data (r_data)
    );

    assign status = state_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory side) of the data-memory request/status interface driven by the pipeline's memory stage.
- Accepts single-word read/write requests and holds each one for a configurable number of wait cycles.
- Commits writes, returns read data, and reports progress on a 2-bit status bus.
- Stands in as the data memory behind the memory stage, so the pipeline can be exercised with realistic multi-cycle memory latency.

Parameters:
- ADDR_W, 10: word-index width; memory holds DEPTH = 2**ADDR_W 32-bit words.
- LATENCY, 2: wait cycles spent in BUSY before completion (0 allowed).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- valid  in  1  request present this cycle.
- write_enabled  in  1  1 = write request, 0 = read request; sampled with valid.
- addr  in  32  byte address.
- w_data  in  32  write data; sampled with valid.
- r_data  out  32  read data; holds the last completed read.
- status  out  2  2'b00 IDLE, 2'b01 BUSY, 2'b10 DONE, 2'b11 ERROR.

Behaviour:
- Encodings for status and the FSM state are identical; status is the registered state.
- Reset (rst = 0, asynchronous): state IDLE, status 2'b00, r_data 32'h0, latency counter 0, captured request cleared. Memory array is not reset.
- Request acceptance:
  - A request is accepted when valid = 1 in IDLE, DONE or ERROR. This allows back-to-back requests.
  - On acceptance, addr, w_data and write_enabled are captured.
  - valid during BUSY is ignored; the captured request is unaffected.
- Error check at acceptance: addr[1:0] != 0 (misaligned) or addr[31:ADDR_W+2] != 0 (out of range) gives next state ERROR.
  - ERROR lasts one cycle.
  - No write is performed; r_data is unchanged.
- Good request, LATENCY > 0: next state BUSY, counter loaded with LATENCY-1.
  - Each BUSY cycle, the counter decrements.
  - When the counter is 0 in BUSY, next state is DONE.
- Good request, LATENCY = 0: next state DONE directly, giving a one-cycle request-to-DONE latency.
- Completion edge (the edge that enters DONE), word index addr[ADDR_W+1:2]:
  - Write: mem[index] <= w_data; r_data unchanged.
  - Read: r_data <= mem[index].
  - r_data is therefore valid while status = DONE and stays stable afterwards.
- Total latency: status reads DONE LATENCY+1 cycles after the accepting edge's cycle; a LATENCY = 2 request shows BUSY, BUSY, DONE.
- DONE and ERROR last one cycle, then:
  - IDLE if valid = 0;
  - the next request's state if valid = 1.
- Read-after-write to the same address in a later request returns the new data. No forwarding is needed because writes commit before DONE.
- Reset asserted mid-BUSY: request aborted, pending write never committed, state returns to IDLE.
- Counter width is clog2(LATENCY+1), minimum 1 bit, so it never wraps within a request.

Decomposition:
- Shared package (mem_if_pkg):
  - status_t enum: IDLE, BUSY, DONE, ERROR with the encodings above.
  - the ERROR alignment-mask constant.
- One sub-module, dmem_array: synchronous single-port 32-bit RAM with a write-enable, word index and write data. The responder FSM drives it on the completion edge.
- FSM, counter, request capture and error check stay in dmem_responder.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release -> status 2'b00, r_data 32'h0; asserting rst mid-cycle clears the outputs immediately.
- Write then read, LATENCY = 2:
  - write addr 32'h10, data 32'hDEADBEEF -> status 01, 01, 10; r_data stays 0.
  - then read addr 32'h10 -> status 01, 01, 10 with r_data = 32'hDEADBEEF.
- Misaligned and out-of-range:
  - write addr 32'h6 -> next status 2'b11 for one cycle, then 00; a subsequent read of 32'h4 returns the prior contents.
  - with ADDR_W = 10, addr 32'h1000 -> 2'b11.
- Back-to-back:
  - valid held high with reads of 32'h0 then 32'h4 -> second request accepted in the DONE cycle; sequence 01, 01, 10, 01, 01, 10.
  - valid toggled during BUSY -> no effect.
- LATENCY = 0 build: read request -> DONE on the very next cycle, with no BUSY.
- Reset during BUSY of a write to 32'h20 with data 32'h12345678 -> after reset, a read of 32'h20 returns the old value, not 32'h12345678.
